// File: rtl/vram_arbiter_if.sv
// Bundles the video, CPU and RAM-port signals shared by the VRAM arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_wait;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata, cpu_wait,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata, cpu_wait,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has priority, a starvation counter forces a CPU slot,
// read data is routed back to its owner through a tag pipeline aligned with RAM latency.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              grant_vid, grant_cpu, tag_new;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [RD_LAT:0]   tag_v_q, tag_v_d;
  logic [RD_LAT:0]   tag_o_q, tag_o_d;     // owner: 1 = CPU, 0 = video
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  // Reset suppresses grants so nothing new enters the pipeline in a reset cycle.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (!reset) begin
      if (bus.vid_req && bus.cpu_req) begin
        if (starve_cnt_q == LIMIT) grant_cpu = 1'b1;
        else                       grant_vid = 1'b1;
      end else if (bus.vid_req) begin
        grant_vid = 1'b1;
      end else if (bus.cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (grant_vid && bus.cpu_req)
      starve_cnt_d = (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : LIMIT;

    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_vid) begin
      ram_addr_d = bus.vid_addr;
    end else if (grant_cpu) begin
      ram_addr_d  = bus.cpu_addr;
      ram_wdata_d = bus.cpu_wdata;
    end
    ram_we_d = grant_cpu & bus.cpu_we;

    tag_new = grant_vid | (grant_cpu & ~bus.cpu_we);
    tag_v_d = {tag_v_q[RD_LAT-1:0], tag_new};
    tag_o_d = {tag_o_q[RD_LAT-1:0], grant_cpu};

    // The last tag stage lines up with ram_rdata for the access it describes.
    vid_rvalid_d = tag_v_q[RD_LAT] & ~tag_o_q[RD_LAT];
    cpu_rvalid_d = tag_v_q[RD_LAT] &  tag_o_q[RD_LAT];
    vid_rdata_d  = vid_rvalid_d ? bus.ram_rdata : vid_rdata_q;
    cpu_rdata_d  = cpu_rvalid_d ? bus.ram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      tag_v_q      <= '0;
      tag_o_q      <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      tag_v_q      <= tag_v_d;
      tag_o_q      <= tag_o_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign bus.vid_ack    = grant_vid;
  assign bus.cpu_ack    = grant_cpu;
  assign bus.cpu_wait   = bus.cpu_req & ~grant_cpu & ~reset;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed cycle checks plus a read-return scoreboard
// drained by a monitor process. Includes a 1-cycle-latency RAM model.
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LAT(1), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic owner, input logic [7:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.vid_rvalid || bus.cpu_rvalid) begin
        chk("rvalid_both", 32'(bus.vid_rvalid & bus.cpu_rvalid), 0);
        if (exp_q.size() == 0) begin
          chk("rvalid_expected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", 32'(bus.cpu_rvalid), 32'(e.owner));
          chk("rdata", e.owner ? 32'(bus.cpu_rdata) : 32'(bus.vid_rdata), 32'(e.data));
        end
      end
    end
  endtask

  // Advance to the next cycle, apply inputs, settle before checking.
  task automatic drv(input logic vr, input logic [12:0] va, input logic cr, input logic cw,
                     input logic [12:0] ca, input logic [7:0] cd);
    @(posedge clk);
    #1;
    bus.vid_req   = vr;
    bus.vid_addr  = va;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_addr"},  32'(bus.ram_addr), 0);
    chk({tag, "_ram_we"},    32'(bus.ram_we), 0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 0);
    chk({tag, "_acks"},      32'({bus.vid_ack, bus.cpu_ack, bus.cpu_wait}), 0);
    chk({tag, "_rvalids"},   32'({bus.vid_rvalid, bus.cpu_rvalid}), 0);
    chk({tag, "_rdata"},     32'({bus.vid_rdata, bus.cpu_rdata}), 0);
  endtask

  initial begin
    bus.vid_req = 1'b0; bus.vid_addr = '0; bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    fork
      monitor();
    join_none

    idle(3);
    chk_all_zero("reset");
    @(posedge clk); #1; reset = 1'b0;

    // Preload through the arbiter.
    drv(1'b0, 13'h0, 1'b1, 1'b1, 13'h1800, 8'hA5);
    chk("pre_cpu_ack", 32'(bus.cpu_ack), 1);
    chk("pre_cpu_wait", 32'(bus.cpu_wait), 0);
    drv(1'b0, 13'h0, 1'b1, 1'b1, 13'h0100, 8'h11);
    drv(1'b0, 13'h0, 1'b1, 1'b1, 13'h0200, 8'h22);
    idle(2);

    // Video read of 0x1800.
    drv(1'b1, 13'h1800, 1'b0, 1'b0, 13'h0, 8'h0);
    chk("t1_vid_ack", 32'({bus.vid_ack, bus.cpu_ack}), 32'b10);
    push(1'b0, 8'hA5);
    idle(1);
    chk("t1_ram_addr", 32'(bus.ram_addr), 'h1800);
    chk("t1_ram_we", 32'(bus.ram_we), 0);
    idle(1);
    chk("t1_rvalid_c2", 32'(bus.vid_rvalid), 0);
    idle(1);
    chk("t1_rvalid_c3", 32'({bus.vid_rvalid, bus.cpu_rvalid}), 32'b10);
    idle(2);

    // CPU write then read-back.
    drv(1'b0, 13'h0, 1'b1, 1'b1, 13'h0123, 8'h5A);
    chk("t2_ack_c0", 32'(bus.cpu_ack), 1);
    chk("t2_we_c0", 32'(bus.ram_we), 0);
    drv(1'b0, 13'h0, 1'b1, 1'b0, 13'h0123, 8'h00);
    chk("t2_ack_c1", 32'(bus.cpu_ack), 1);
    chk("t2_we_c1", 32'(bus.ram_we), 1);
    push(1'b1, 8'h5A);
    idle(1);
    chk("t2_we_c2", 32'(bus.ram_we), 0);
    idle(1);
    chk("t2_rvalid_c3", 32'(bus.cpu_rvalid), 0);
    idle(1);
    chk("t2_rvalid_c4", 32'(bus.cpu_rvalid), 1);
    idle(2);

    // Sustained contention: V,V,V,C,V,V,V,C.
    for (int i = 0; i < 8; i++) begin
      logic c;
      c = (i == 3) || (i == 7);
      drv(1'b1, 13'h0100, 1'b1, 1'b0, 13'h0200, 8'h00);
      chk("t3_cpu_ack", 32'(bus.cpu_ack), 32'(c));
      chk("t3_vid_ack", 32'(bus.vid_ack), 32'(!c));
      chk("t3_cpu_wait", 32'(bus.cpu_wait), 32'(!c));
      push(c, c ? 8'h22 : 8'h11);
    end
    idle(4);

    // A CPU gap clears the starvation count.
    for (int i = 0; i < 7; i++) begin
      logic cr, c;
      cr = (i != 2);
      c  = (i == 6);
      drv(1'b1, 13'h0100, cr, 1'b0, 13'h0200, 8'h00);
      chk("t4_cpu_ack", 32'(bus.cpu_ack), 32'(c));
      chk("t4_vid_ack", 32'(bus.vid_ack), 32'(!c));
      push(c, c ? 8'h22 : 8'h11);
    end
    idle(4);

    // Reset drops an in-flight read and overrides a request.
    drv(1'b1, 13'h1800, 1'b0, 1'b0, 13'h0, 8'h0);
    chk("t5_vid_ack", 32'(bus.vid_ack), 1);
    reset = 1'b1;
    drv(1'b1, 13'h1800, 1'b1, 1'b0, 13'h0200, 8'h0);
    chk("t5_reset_wins", 32'({bus.vid_ack, bus.cpu_ack, bus.cpu_wait}), 0);
    idle(1);
    chk_all_zero("t5_reset");
    @(posedge clk); #1; reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_rvalid", 32'({bus.vid_rvalid, bus.cpu_rvalid}), 0);
      idle(1);
    end
    drv(1'b1, 13'h1800, 1'b0, 1'b0, 13'h0, 8'h0);
    chk("t5_after_ack", 32'(bus.vid_ack), 1);
    push(1'b0, 8'hA5);
    idle(4);

    // Video read followed by CPU write to the same address returns old data.
    drv(1'b1, 13'h0123, 1'b0, 1'b0, 13'h0, 8'h0);
    push(1'b0, 8'h5A);
    drv(1'b0, 13'h0, 1'b1, 1'b1, 13'h0123, 8'h77);
    chk("t6_cpu_ack", 32'(bus.cpu_ack), 1);
    chk("t6_we_c1", 32'(bus.ram_we), 0);
    idle(1);
    chk("t6_we_c2", 32'(bus.ram_we), 1);
    chk("t6_wdata_c2", 32'(bus.ram_wdata), 'h77);
    idle(1);
    chk("t6_rvalid_c3", 32'({bus.vid_rvalid, bus.cpu_rvalid, bus.ram_we}), 32'b100);
    idle(1);
    chk("t6_no_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    drv(1'b0, 13'h0, 1'b1, 1'b0, 13'h0123, 8'h00);
    push(1'b1, 8'h77);
    idle(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
